conv2_sched: RTL and testbench



---
 rtl/conv2_pkg.sv | 25 ++
 rtl/conv2_addr_gen.sv | 53 +++++
 rtl/conv2_sched.sv | 95 +++++++++
 tb/tb_conv2_sched.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/conv2_pkg.sv
// conv2_pkg: LeNet conv2 geometry, address strides, scheduler states and requantisation helper
package conv2_pkg;
    localparam int IN_DIM = 14;
    localparam int OUT_DIM = 10;
    localparam int K_DIM = 5;
    localparam int N_CH = 2;
    localparam int N_K = 2;
    localparam int TAPS = N_CH * K_DIM * K_DIM;
    localparam int N_OUT = N_K * OUT_DIM * OUT_DIM;
    localparam int FM_CH_STRIDE = IN_DIM * IN_DIM;
    localparam int FM_ROW_STRIDE = IN_DIM;
    localparam int KN_K_STRIDE = TAPS;
    localparam int KN_CH_STRIDE = K_DIM * K_DIM;
    localparam int KN_ROW_STRIDE = K_DIM;

    typedef enum logic [2:0] {IDLE, ISSUE, DRAIN, OUT, DONE} state_t;

    function automatic logic signed [63:0] sat_shift(input logic signed [63:0] a, input int frac, input int bw);
        logic signed [63:0] s, hi, lo;
        s = a >>> frac;
        hi = (64'sd1 <<< (bw - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        return s > hi ? hi : (s < lo ? lo : s);
    endfunction
endpackage

// File: rtl/conv2_addr_gen.sv
// conv2_addr_gen: output/tap counters and feature/kernel address arithmetic for conv2
module conv2_addr_gen
    import conv2_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       restart,
    input  logic       step,
    input  logic       adv,
    output logic [8:0] fm_addr,
    output logic [6:0] kn_addr,
    output logic [7:0] idx,
    output logic       first_tap,
    output logic       last_tap,
    output logic       last_out
);
    logic       k, ch;
    logic [3:0] r, c;
    logic [2:0] l, m;

    always_ff @(posedge clk) begin
        if (!rst_n || restart) begin
            k <= 1'b0;
            r <= '0;
            c <= '0;
            ch <= 1'b0;
            l <= '0;
            m <= '0;
        end else if (adv) begin
            ch <= 1'b0;
            l <= '0;
            m <= '0;
            c <= c == 4'(OUT_DIM - 1) ? 4'd0 : c + 4'd1;
            if (c == 4'(OUT_DIM - 1))
                r <= r == 4'(OUT_DIM - 1) ? 4'd0 : r + 4'd1;
            if (c == 4'(OUT_DIM - 1) && r == 4'(OUT_DIM - 1))
                k <= !k;
        end else if (step) begin
            m <= m == 3'(K_DIM - 1) ? 3'd0 : m + 3'd1;
            if (m == 3'(K_DIM - 1))
                l <= l == 3'(K_DIM - 1) ? 3'd0 : l + 3'd1;
            if (m == 3'(K_DIM - 1) && l == 3'(K_DIM - 1))
                ch <= !ch;
        end
    end

    assign fm_addr = (ch ? 9'(FM_CH_STRIDE) : 9'd0) + (9'(r) + 9'(l)) * 9'(FM_ROW_STRIDE) + 9'(c) + 9'(m);
    assign kn_addr = (k ? 7'(KN_K_STRIDE) : 7'd0) + (ch ? 7'(KN_CH_STRIDE) : 7'd0) + 7'(l) * 7'(KN_ROW_STRIDE) + 7'(m);
    assign idx = (k ? 8'(N_OUT / N_K) : 8'd0) + 8'(r) * 8'(OUT_DIM) + 8'(c);
    assign first_tap = !ch && l == 3'd0 && m == 3'd0;
    assign last_tap = ch && l == 3'(K_DIM - 1) && m == 3'(K_DIM - 1);
    assign last_out = idx == 8'(N_OUT - 1);
endmodule

// File: rtl/conv2_sched.sv
// conv2_sched: time-multiplexed LeNet conv2 sequencer driving memories, an external MAC and a requantised output stream
module conv2_sched
    import conv2_pkg::*;
#(
    parameter int BW = 16,
    parameter int ACC_W = 40,
    parameter int FRAC = 15,
    parameter int RD_LAT = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    output logic                    busy,
    output logic                    done,
    output logic [8:0]              fm_addr,
    output logic [6:0]              kn_addr,
    output logic                    mac_en,
    output logic                    mac_clr,
    input  logic signed [ACC_W-1:0] acc_in,
    output logic [BW-1:0]           out_data,
    output logic [7:0]              out_idx,
    output logic                    out_valid,
    input  logic                    out_ready
);
    localparam int DW = $clog2(RD_LAT + 2);

    state_t state, nxt;
    logic [RD_LAT-1:0] pv, pf;
    logic [DW-1:0] dcnt;
    logic [7:0] idx;
    logic issue, first_tap, last_tap, last_out, last_drain, hs;

    assign issue = state == ISSUE;
    assign hs = out_valid && out_ready;
    assign last_drain = state == DRAIN && dcnt == DW'(RD_LAT);
    assign busy = state != IDLE;
    assign done = state == DONE;
    assign mac_en = pv[RD_LAT-1];
    assign mac_clr = pf[RD_LAT-1];

    conv2_addr_gen u_addr (
        .clk      (clk),
        .rst_n    (rst_n),
        .restart  (state == IDLE && start),
        .step     (issue && !last_tap),
        .adv      (hs && !last_out),
        .fm_addr  (fm_addr),
        .kn_addr  (kn_addr),
        .idx      (idx),
        .first_tap(first_tap),
        .last_tap (last_tap),
        .last_out (last_out)
    );

    always_ff @(posedge clk) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= nxt;
    end

    always_comb begin
        nxt = state;
        case (state)
            IDLE:    nxt = start ? ISSUE : IDLE;
            ISSUE:   nxt = last_tap ? DRAIN : ISSUE;
            DRAIN:   nxt = last_drain ? OUT : DRAIN;
            OUT:     nxt = hs ? (last_out ? DONE : ISSUE) : OUT;
            default: nxt = IDLE;
        endcase
    end

    // tap-valid/first-tap delayed by RD_LAT so MAC control lines up with read data
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pv <= '0;
            pf <= '0;
            dcnt <= '0;
            out_valid <= 1'b0;
            out_data <= '0;
            out_idx <= '0;
        end else begin
            pv <= RD_LAT'({pv, issue});
            pf <= RD_LAT'({pf, issue && first_tap});
            dcnt <= state == DRAIN ? dcnt + DW'(1) : '0;
            if (last_drain) begin
                out_valid <= 1'b1;
                out_data <= BW'(sat_shift(64'(acc_in), FRAC, BW));
                out_idx <= idx;
            end else if (hs) begin
                out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_conv2_sched.sv
// tb_conv2_sched: directed self-checking bench for the conv2 scheduler
module tb_conv2_sched;
    logic clk, rst_n, start, busy, done, mac_en, mac_clr, out_valid, out_ready;
    logic [8:0] fm_addr;
    logic [6:0] kn_addr;
    logic signed [39:0] acc_in;
    logic [15:0] out_data;
    logic [7:0] out_idx;
    int n_chk, n_fail, cyc, done_cnt, t0;

    conv2_sched dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
        .fm_addr(fm_addr), .kn_addr(kn_addr), .mac_en(mac_en), .mac_clr(mac_clr),
        .acc_in(acc_in), .out_data(out_data), .out_idx(out_idx),
        .out_valid(out_valid), .out_ready(out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (done === 1'b1) done_cnt <= done_cnt + 1;

    task automatic check(input string tag, input longint got, input longint exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_fm", fm_addr, 0);
        check("rst_kn", kn_addr, 0);
        check("rst_mac_en", mac_en, 0);
        check("rst_mac_clr", mac_clr, 0);
        check("rst_data", out_data, 0);
        check("rst_idx", out_idx, 0);
        check("rst_valid", out_valid, 0);
    endtask

    task automatic pattern(input int o, output logic signed [39:0] a, output logic [15:0] e);
        longint v;
        logic [15:0] d;
        d = 16'(o);
        v = longint'(o) * 32768 + 100;
        case (o)
            0: begin v = 3 * 32768; d = 16'd3; end
            1: begin v = -1; d = 16'hffff; end
            2: begin v = 64'sd2147483648; d = 16'h7fff; end
            3: begin v = -64'sd2147483648; d = 16'h8000; end
            4: begin v = 32767; d = 16'h0000; end
            5: begin v = -5 * 32768 - 1; d = 16'hfffa; end
            6: begin v = 32767 * 32768; d = 16'h7fff; end
            7: begin v = 32768 * 32768; d = 16'h7fff; end
            8: begin v = -32768 * 32768; d = 16'h8000; end
            9: begin v = -32769 * 32768; d = 16'h8000; end
            default: ;
        endcase
        a = 40'(v);
        e = d;
    endtask

    task automatic run_output(input int o, input int stall);
        int k, r, c, n, ch, l, m;
        logic signed [39:0] a;
        logic [15:0] e;
        k = o / 100;
        r = (o / 10) % 10;
        c = o % 10;
        pattern(o, a, e);
        acc_in = a;
        n = 0;
        while (!out_valid && n < 100) begin
            if (n < 50) begin
                ch = n / 25;
                l = (n % 25) / 5;
                m = n % 5;
                check("tap_fm", fm_addr, ch * 196 + (r + l) * 14 + c + m);
                check("tap_kn", kn_addr, k * 50 + n);
            end
            check("mac_en", mac_en, n >= 1 && n <= 50);
            check("mac_clr", mac_clr, n == 1);
            tick;
            n++;
        end
        check("latency", n, 52);
        check("out_data", out_data, e);
        check("out_idx", out_idx, o);
        check("hold_fm", fm_addr, 196 + (r + 4) * 14 + c + 4);
        check("hold_kn", kn_addr, k * 50 + 49);
        for (int i = 0; i < stall; i++) begin
            tick;
            check("stall_valid", out_valid, 1);
            check("stall_data", out_data, e);
            check("stall_idx", out_idx, o);
            check("stall_fm", fm_addr, 196 + (r + 4) * 14 + c + 4);
            check("stall_mac_en", mac_en, 0);
        end
        out_ready = 1'b1;
        tick;
        check("valid_clr", out_valid, 0);
        if (o < 199) check("next_fm", fm_addr, (((o + 1) / 10) % 10) * 14 + (o + 1) % 10);
    endtask

    initial begin
        n_chk = 0; n_fail = 0; cyc = 0; done_cnt = 0;
        rst_n = 1'b0; start = 1'b0; out_ready = 1'b1; acc_in = '0;
        repeat (3) tick;
        check_reset;
        rst_n = 1'b1;
        tick;
        start = 1'b1;
        tick;
        start = 1'b0;
        t0 = cyc;
        for (int o = 0; o < 200; o++) run_output(o, 0);
        check("pass_cycles", cyc - t0, 10600);
        check("done_pulse", done, 1);
        check("busy_at_done", busy, 1);
        check("last_fm", fm_addr, 391);
        tick;
        check("done_fall", done, 0);
        check("busy_fall", busy, 0);
        check("done_count", done_cnt, 1);
        start = 1'b1;
        tick;
        start = 1'b0;
        out_ready = 1'b0;
        run_output(0, 10);
        for (int o = 1; o < 57; o++) run_output(o, 0);
        repeat (3) tick;
        rst_n = 1'b0;
        tick;
        check_reset;
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick;
            check("post_rst_mac_en", mac_en, 0);
            check("post_rst_busy", busy, 0);
        end
        start = 1'b1;
        tick;
        start = 1'b0;
        check("restart_fm", fm_addr, 0);
        check("restart_kn", kn_addr, 0);
        check("restart_busy", busy, 1);
        repeat (5) tick;
        check("tap5_fm", fm_addr, 14);
        start = 1'b1;
        tick;
        start = 1'b0;
        check("start_busy_fm", fm_addr, 15);
        check("start_busy_kn", kn_addr, 6);
        acc_in = 40'sd7 <<< 15;
        for (int i = 0; i < 100 && !out_valid; i++) tick;
        check("restart_valid", out_valid, 1);
        check("restart_idx", out_idx, 0);
        check("restart_data", out_data, 7);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
